// File: rtl/shift_frame_pkg.sv
// Shared definitions for the serial frame receiver: state encoding and
// derived timing/width helpers used by the controller.
package shift_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Start bit is re-checked half a bit period after the falling edge.
    function automatic int half_of(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

    // Counter width for a modulus n, never collapsing to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_frame_ctrl_if.sv
// Serial line in, received word and status out; the controller is the slave,
// whoever drives the line and consumes the words is the master.
interface shift_frame_ctrl_if #(
    parameter int MSB = 8
);
    logic           serial_in;
    logic           dir;
    logic [MSB-1:0] data_out;
    logic           data_valid;
    logic           frame_err;
    logic           busy;

    modport master (
        output serial_in, dir,
        input  data_out, data_valid, frame_err, busy
    );

    modport slave (
        input  serial_in, dir,
        output data_out, data_valid, frame_err, busy
    );
endinterface

// File: rtl/shift_reg.sv
// Serial-in shift register; dir=0 shifts towards the LSB (LSB-first frames
// land in natural order), dir=1 shifts towards the MSB.
module shift_reg #(
    parameter int MSB = 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           en,
    input  logic           d,
    input  logic           dir,
    output logic [MSB-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (en) begin
            q <= dir ? {q[MSB-2:0], d} : {d, q[MSB-1:1]};
        end
    end

endmodule

// File: rtl/shift_frame_ctrl.sv
// Frame receiver: finds the start bit, samples each data bit mid-period into
// shift_reg and checks the stop bit before publishing the word.
module shift_frame_ctrl
    import shift_frame_pkg::*;
#(
    parameter int MSB          = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                clk,
    input  logic                rstn,
    shift_frame_ctrl_if.slave   bus
);

    localparam int HALF  = half_of(CLKS_PER_BIT);
    localparam int CYC_W = cnt_width(CLKS_PER_BIT);
    localparam int BIT_W = cnt_width(MSB);

    localparam logic [CYC_W-1:0] LAST_CYC  = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [CYC_W-1:0] HALF_LAST = CYC_W'(HALF - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(MSB - 1);

    state_t           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             dir_q, dir_d;
    logic             sr_en;
    logic             valid_d, err_d;
    logic [MSB-1:0]   sr_q;
    logic [MSB-1:0]   data_q;
    logic             valid_q, err_q;

    shift_reg #(.MSB(MSB)) u_shift_reg (
        .clk  (clk),
        .rstn (rstn),
        .en   (sr_en),
        .d    (bus.serial_in),
        .dir  (dir_q),
        .q    (sr_q)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q + 1'b1;
        bit_d   = bit_q;
        dir_d   = dir_q;
        sr_en   = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cyc_d = '0;
                if (!bus.serial_in) begin
                    state_d = START;
                    bit_d   = '0;
                    dir_d   = bus.dir;
                end
            end
            START: begin
                // A line that is high again mid start bit was a glitch.
                if (cyc_q == HALF_LAST) begin
                    cyc_d   = '0;
                    state_d = bus.serial_in ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cyc_q == LAST_CYC) begin
                    cyc_d = '0;
                    sr_en = 1'b1;
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (cyc_q == LAST_CYC) begin
                    cyc_d   = '0;
                    state_d = IDLE;
                    valid_d = bus.serial_in;
                    err_d   = !bus.serial_in;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: only control and datapath registers are reset here; there is no
    // memory array, so the whole state is cleared by rstn.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            dir_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            dir_q   <= dir_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            if (valid_d) begin
                data_q <= sr_q;
            end
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = err_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Self-checking bench: drives whole frames on the serial line and compares the
// observed pulses against a frame-level model of when and what should appear.
module tb_shift_frame_ctrl;

    localparam int MSB          = 8;
    localparam int CLKS_PER_BIT = 4;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int STOP_OFS     = HALF + CLKS_PER_BIT * (MSB + 1);

    typedef struct {
        int unsigned    cyc;
        bit             err;
        logic [MSB-1:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rstn;
    int unsigned cycle = 0;
    int checks = 0;
    int errors = 0;

    ev_t exp_q[$];
    ev_t got_q[$];
    logic [MSB-1:0] last_good;

    shift_frame_ctrl_if #(.MSB(MSB)) bus ();

    shift_frame_ctrl #(
        .MSB          (MSB),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Record every output pulse with the cycle it became visible.
    always @(negedge clk) begin
        if (rstn && (bus.data_valid || bus.frame_err)) begin
            check("pulse_exclusive", {31'd0, bus.data_valid & bus.frame_err}, 32'd0);
            got_q.push_back('{cyc: cycle, err: bus.frame_err, data: bus.data_out});
        end
    end

    function automatic logic [MSB-1:0] reverse(input logic [MSB-1:0] v);
        logic [MSB-1:0] r;
        for (int i = 0; i < MSB; i++) r[i] = v[MSB-1-i];
        return r;
    endfunction

    // Data is transmitted LSB first; dir=1 collects it in reversed order.
    task automatic send_frame(input logic [MSB-1:0] data, input logic stop_bit,
                              input logic d, input bit toggle);
        logic [MSB+1:0] bits;
        logic [MSB-1:0] word;
        int unsigned t0;
        bits = {stop_bit, data, 1'b0};
        bus.dir = d;
        t0 = cycle + 1;
        word = d ? reverse(data) : data;
        if (stop_bit) begin
            exp_q.push_back('{cyc: t0 + STOP_OFS, err: 1'b0, data: word});
            last_good = word;
        end else begin
            exp_q.push_back('{cyc: t0 + STOP_OFS, err: 1'b1, data: last_good});
        end
        for (int i = 0; i < MSB + 2; i++) begin
            bus.serial_in = bits[i];
            for (int c = 0; c < CLKS_PER_BIT; c++) begin
                @(negedge clk);
                if (toggle) bus.dir = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic idle(input int n);
        bus.serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic compare_events(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_cycle"}, got_q[i].cyc, exp_q[i].cyc);
            check({tag, "_kind"},  {31'd0, got_q[i].err}, {31'd0, exp_q[i].err});
            check({tag, "_data"},  {24'd0, got_q[i].data}, {24'd0, exp_q[i].data});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int busy_cnt;
        logic [MSB-1:0] rd;
        logic st;

        rstn = 1'b0;
        bus.serial_in = 1'b1;
        bus.dir = 1'b0;
        last_good = '0;
        repeat (3) @(negedge clk);
        check("rst_data_out", {24'd0, bus.data_out}, 32'd0);
        check("rst_valid",    {31'd0, bus.data_valid}, 32'd0);
        check("rst_err",      {31'd0, bus.frame_err}, 32'd0);
        check("rst_busy",     {31'd0, bus.busy}, 32'd0);
        rstn = 1'b1;
        idle(3);

        // Reference frame 0,1,0,0,1,0,1,1 LSB first, good stop bit.
        send_frame(8'hD2, 1'b1, 1'b0, 1'b0);
        idle(4);
        compare_events("ref_good");
        check("ref_word", {24'd0, bus.data_out}, 32'h0000_00D2);

        // Same frame with a bad stop bit; the line has to settle before reuse.
        send_frame(8'hD2, 1'b0, 1'b0, 1'b0);
        idle(5);
        compare_events("ref_stop_err");
        check("ref_err_keeps", {24'd0, bus.data_out}, 32'h0000_00D2);

        // One-cycle low glitch: START must give up after HALF cycles.
        bus.serial_in = 1'b0;
        @(negedge clk);
        busy_cnt = int'(bus.busy);
        bus.serial_in = 1'b1;
        repeat (5) begin
            @(negedge clk);
            busy_cnt += int'(bus.busy);
        end
        check("glitch_busy_cycles", busy_cnt, 2);
        compare_events("glitch");

        // Back-to-back frames with no idle gap.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(4);
        check("b2b_spacing", (got_q.size() == 2) ? got_q[1].cyc - got_q[0].cyc : 0, 40);
        compare_events("b2b");

        // dir wiggling mid-frame must not change the received word.
        send_frame(8'hD2, 1'b1, 1'b0, 1'b1);
        idle(4);
        compare_events("dir_toggle");

        // Randomized frames: data, stop bit, captured dir, dir noise, gaps.
        for (int f = 0; f < 40; f++) begin
            rd = MSB'($urandom);
            st = ($urandom_range(0, 7) != 0);
            send_frame(rd, st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (!st) idle(3 + $urandom_range(0, 2));
            else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(4);
        compare_events("random");

        // Reset in the middle of data bit 4 of a 0xFF frame.
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        idle(2);
        compare_events("pre_reset");
        bus.serial_in = 1'b0;
        repeat (CLKS_PER_BIT) @(negedge clk);
        bus.serial_in = 1'b1;
        repeat (CLKS_PER_BIT * 4 + 2) @(negedge clk);
        check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
        rstn = 1'b0;
        #1;
        check("midrst_data_out", {24'd0, bus.data_out}, 32'd0);
        check("midrst_busy",     {31'd0, bus.busy}, 32'd0);
        check("midrst_valid",    {31'd0, bus.data_valid}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        last_good = '0;
        idle(2 * CLKS_PER_BIT * MSB);
        compare_events("abandoned");
        check("post_rst_data_out", {24'd0, bus.data_out}, 32'd0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        idle(4);
        compare_events("after_reset");
        check("after_reset_word", {24'd0, bus.data_out}, 32'h0000_00FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
